// File: rtl/divider_sequential_if.sv
// Request/result bundle for the sequential divider: operands and start from
// the requester, quotient/remainder and status flags back from the divider.
interface divider_sequential_if #(
    parameter int WIDTH_DIVISOR  = 4,
    parameter int WIDTH_DIVIDEND = 8
);
    logic                      start;
    logic [WIDTH_DIVIDEND-1:0] dividend;
    logic [WIDTH_DIVISOR-1:0]  divisor;
    logic [WIDTH_DIVIDEND-1:0] quotient;
    logic [WIDTH_DIVISOR-1:0]  remainder;
    logic                      busy;
    logic                      done;
    logic                      divide_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, divide_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, divide_by_zero
    );
endinterface

// File: rtl/divider_sequential.sv
// Restoring shift-subtract unsigned divider: 2N-bit dividend by N-bit divisor,
// one quotient bit per clock, start/busy/done handshake.
module divider_sequential #(
    parameter int WIDTH_DIVISOR  = 4,
    parameter int WIDTH_DIVIDEND = 8
) (
    input  logic               clock,
    input  logic               reset,
    divider_sequential_if.slave bus
);
    localparam int N  = WIDTH_DIVISOR;
    localparam int W  = WIDTH_DIVIDEND;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [CW-1:0]   counter_reg;
    logic [W-1:0]    dvd_reg;
    logic [N-1:0]    dvs_reg;
    logic [N-1:0]    rem_reg;
    logic [W-1:0]    quotient_reg;
    logic [N-1:0]    remainder_reg;
    logic            dbz_reg;

    logic [N:0]      shifted;
    logic [N:0]      trial;
    logic            trial_ok;

    // The stored partial remainder is always below the divisor, so N bits
    // hold it; the shift brings it up to N+1 bits for the trial subtraction.
    always_comb begin
        shifted  = {rem_reg, dvd_reg[W-1]};
        trial    = shifted - {1'b0, dvs_reg};
        trial_ok = ~trial[N];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (bus.start) state_next = S_RUN;
            S_RUN:   if (counter_reg == '0) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter_reg   <= '0;
            dvd_reg       <= '0;
            dvs_reg       <= '0;
            rem_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        dvd_reg <= bus.dividend;
                        dvs_reg <= bus.divisor;
                        rem_reg <= '0;
                        dbz_reg <= 1'b0;
                        // A zero divisor skips the iterations and goes straight
                        // to the result-write edge.
                        counter_reg <= (bus.divisor == '0) ? '0 : CW'(W);
                    end
                end
                S_RUN: begin
                    if (counter_reg == '0) begin
                        if (dvs_reg == '0) begin
                            quotient_reg  <= '1;
                            remainder_reg <= '0;
                            dbz_reg       <= 1'b1;
                        end else begin
                            quotient_reg  <= dvd_reg;
                            remainder_reg <= rem_reg;
                        end
                    end else begin
                        rem_reg     <= trial_ok ? trial[N-1:0] : shifted[N-1:0];
                        dvd_reg     <= {dvd_reg[W-2:0], trial_ok};
                        counter_reg <= counter_reg - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy           = (state_reg == S_RUN);
    assign bus.done           = (state_reg == S_DONE);
    assign bus.quotient       = quotient_reg;
    assign bus.remainder      = remainder_reg;
    assign bus.divide_by_zero = dbz_reg;
endmodule
